// File: rtl/msc_multi.sv
// rtl/msc_multi.sv - multi-port memory controller register block with reset/flush sequencing
//
// Each port has two registers: a control register at an even address and a page
// register at the next odd address. Reset and flush requests are posted into
// pending bits. Each pending bit is issued as a single-cycle pulse once its port
// is idle.
//
// Ports:
//   clk        - single clock; all state is updated on the rising edge
//   rst_n      - synchronous active-low reset
//   wren       - register write strobe
//   A          - register address; port = A>>1, A[0]=0 control, A[0]=1 page
//   data       - write data
//   rdata      - combinational readback of register A
//   page       - per-port page, port p at [p*PAGE_W +: PAGE_W]
//   port_req   - per-port memory request level
//   port_ready - per-port transaction-complete strobe
//   port_reset - per-port reset pulse (held high while rst_n is low)
//   port_flush - per-port flush pulse
//   busy       - any reset or flush still pending
module msc_multi #(
  parameter  int NPORTS = 2,
  parameter  int PAGE_W = 7,
  localparam int AW     = (2 * NPORTS > 2) ? $clog2(2 * NPORTS) : 1,
  localparam int DW     = PAGE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wren,
  input  logic [AW-1:0]            A,
  input  logic [DW-1:0]            data,
  output logic [DW-1:0]            rdata,
  output logic [NPORTS*PAGE_W-1:0] page,
  input  logic [NPORTS-1:0]        port_req,
  input  logic [NPORTS-1:0]        port_ready,
  output logic [NPORTS-1:0]        port_reset,
  output logic [NPORTS-1:0]        port_flush,
  output logic                     busy
);

  logic [NPORTS-1:0][PAGE_W-1:0] page_q;
  logic [NPORTS-1:0] enable;
  logic [NPORTS-1:0] active;
  logic [NPORTS-1:0] prev_req;
  logic [NPORTS-1:0] reset_pending;
  logic [NPORTS-1:0] flush_pending;

  logic [NPORTS-1:0] idle;
  logic [NPORTS-1:0] fire_reset;
  logic [NPORTS-1:0] fire_flush;
  logic [NPORTS-1:0] wr_ctrl;
  logic [NPORTS-1:0] wr_page;
  logic [AW-1:0]     a_port;

  // An address whose port index is NPORTS or higher matches no port.
  // Writes to it are therefore dropped, and reads of it return zero.
  assign a_port = A >> 1;

  always_comb begin
    wr_ctrl = '0;
    wr_page = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (wren && a_port == AW'(p)) begin
        wr_ctrl[p] = ~A[0];
        wr_page[p] = A[0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (a_port == AW'(p)) begin
        if (A[0])
          rdata = page_q[p];
        else
          rdata = DW'({enable[p], active[p], flush_pending[p], reset_pending[p]});
      end
    end
  end

  assign idle       = (~active & ~port_req) | port_ready;
  assign fire_reset = reset_pending & idle;
  // A pending reset outranks a pending flush. The reset also clears the flush.
  assign fire_flush = flush_pending & idle & ~reset_pending;
  assign port_reset = fire_reset | {NPORTS{~rst_n}};
  assign port_flush = fire_flush & {NPORTS{rst_n}};
  assign busy       = |(reset_pending | flush_pending);
  assign page       = page_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page_q        <= '0;
      enable        <= '0;
      active        <= '0;
      prev_req      <= '0;
      flush_pending <= '0;
      // Every port emits one more reset pulse after rst_n is released.
      reset_pending <= '1;
    end else begin
      prev_req <= port_req;
      for (int p = 0; p < NPORTS; p++) begin
        if (port_ready[p])
          active[p] <= 1'b0;
        else if (port_req[p] && !prev_req[p])
          active[p] <= 1'b1;

        // The request bits act only if enable was already set before this
        // write. A new request in the same cycle as an issue leaves the bit set.
        if (wr_ctrl[p]) begin
          enable[p]        <= data[3];
          reset_pending[p] <= (enable[p] & data[0]) | (reset_pending[p] & ~fire_reset[p]);
          flush_pending[p] <= (enable[p] & data[1]) |
                              (flush_pending[p] & ~fire_reset[p] & ~fire_flush[p]);
        end else begin
          reset_pending[p] <= reset_pending[p] & ~fire_reset[p];
          flush_pending[p] <= flush_pending[p] & ~fire_reset[p] & ~fire_flush[p];
        end

        if (wr_page[p] && enable[p])
          page_q[p] <= data;
      end
    end
  end

endmodule

// File: tb/tb_msc_multi.sv
// tb/tb_msc_multi.sv - scoreboard bench for msc_multi (NPORTS=2, PAGE_W=7)
module tb_msc_multi;

  localparam int NPORTS = 2;
  localparam int PAGE_W = 7;
  localparam int AW     = 2;
  localparam int DW     = PAGE_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wren;
  logic [AW-1:0]            A;
  logic [DW-1:0]            data;
  logic [DW-1:0]            rdata;
  logic [NPORTS*PAGE_W-1:0] page;
  logic [NPORTS-1:0]        port_req;
  logic [NPORTS-1:0]        port_ready;
  logic [NPORTS-1:0]        port_reset;
  logic [NPORTS-1:0]        port_flush;
  logic                     busy;

  msc_multi #(.NPORTS(NPORTS), .PAGE_W(PAGE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wren       (wren),
    .A          (A),
    .data       (data),
    .rdata      (rdata),
    .page       (page),
    .port_req   (port_req),
    .port_ready (port_ready),
    .port_reset (port_reset),
    .port_flush (port_flush),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Selectors for register-style checks.
  localparam int S_RDATA = 0, S_PAGE = 1, S_BUSY = 2, S_PRST = 3, S_PFL = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } reg_chk_t;

  typedef struct {
    int         ph;
    logic [1:0] rst;
    logic [1:0] fl;
  } pulse_t;

  reg_chk_t rq[$];
  pulse_t   pq[$];
  int       phase = 0;
  int       n_vec = 0;
  int       n_bad = 0;

  reg_chk_t    rc;
  pulse_t      pe;
  logic [31:0] act;

  // The monitor samples on the falling edge. It drains the register checks and
  // matches every observed reset/flush pulse against the expected-pulse queue.
  always @(negedge clk) begin
    while (rq.size() > 0) begin
      rc = rq.pop_front();
      case (rc.sel)
        S_RDATA: act = 32'(rdata);
        S_PAGE:  act = 32'(page);
        S_BUSY:  act = 32'(busy);
        S_PRST:  act = 32'(port_reset);
        default: act = 32'(port_flush);
      endcase
      n_vec++;
      if (act !== rc.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", rc.name, act, rc.exp);
      end
    end
    if (rst_n === 1'b1 && (port_reset != 2'b00 || port_flush != 2'b00)) begin
      n_vec++;
      if (pq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse phase %0d: reset=%b flush=%b expected none",
                 phase, port_reset, port_flush);
      end else begin
        pe = pq.pop_front();
        if (pe.ph != phase || pe.rst !== port_reset || pe.fl !== port_flush) begin
          n_bad++;
          $display("FAIL pulse: got phase %0d reset=%b flush=%b expected phase %0d reset=%b flush=%b",
                   phase, port_reset, port_flush, pe.ph, pe.rst, pe.fl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren = 1'b1;
    A    = a;
    data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    reg_chk_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    rq.push_back(e);
  endtask

  task automatic chk_rd(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    A = a;
    chk(name, S_RDATA, exp);
    tick();
  endtask

  task automatic exp_pulse(input int ph, input logic [1:0] r, input logic [1:0] f);
    pulse_t e;
    e.ph  = ph;
    e.rst = r;
    e.fl  = f;
    pq.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; wren = 1'b0; A = '0; data = '0;
    port_req = '0; port_ready = '0;
    repeat (3) tick();

    // In reset.
    chk("rst_port_reset", S_PRST, 32'h3);
    chk("rst_port_flush", S_PFL, 32'h0);
    chk("rst_busy", S_BUSY, 32'h1);
    chk("rst_page", S_PAGE, 32'h0);
    tick();

    // Release: one reset pulse on both ports, then busy falls.
    phase = 1;
    exp_pulse(1, 2'b11, 2'b00);
    rst_n = 1'b1;
    chk("release_busy_hi", S_BUSY, 32'h1);
    tick();
    chk("release_busy_lo", S_BUSY, 32'h0);
    chk_rd("release_ctrl0", 2'd0, 32'h0);

    // Unlocked page write on port 1; locked page write on port 0 is dropped.
    phase = 2;
    wr(2'd2, 7'h08);
    wr(2'd3, 7'h5A);
    chk("page_p1", S_PAGE, {18'h0, 7'h5A, 7'h00});
    chk_rd("rd_page1", 2'd3, 32'h5A);
    chk_rd("rd_ctrl1", 2'd2, 32'h08);
    wr(2'd1, 7'h33);
    chk("page_p0_locked", S_PAGE, {18'h0, 7'h5A, 7'h00});
    tick();

    // Port 0 reset deferred until port_ready.
    phase = 3;
    wr(2'd0, 7'h08);
    port_req[0] = 1'b1;
    tick();
    wr(2'd0, 7'h09);
    chk_rd("ctrl0_pending", 2'd0, 32'h0D);
    chk("busy_p0", S_BUSY, 32'h1);
    repeat (3) tick();
    phase = 4;
    exp_pulse(4, 2'b01, 2'b00);
    port_ready[0] = 1'b1;
    tick();
    port_ready[0] = 1'b0;
    chk_rd("ctrl0_after_rst", 2'd0, 32'h08);
    port_req[0] = 1'b0;
    tick();

    // Port 1 reset+flush while busy: only the reset fires.
    phase = 5;
    port_req[1] = 1'b1;
    tick();
    wr(2'd2, 7'h0B);
    chk_rd("ctrl1_both", 2'd2, 32'h0F);
    tick();
    phase = 6;
    exp_pulse(6, 2'b10, 2'b00);
    port_ready[1] = 1'b1;
    port_req[1]   = 1'b0;
    tick();
    port_ready[1] = 1'b0;
    repeat (3) tick();
    chk_rd("ctrl1_cleared", 2'd2, 32'h08);
    chk("busy_idle", S_BUSY, 32'h0);
    tick();

    // Port 0 flush written twice while active: one pulse.
    phase = 7;
    port_req[0] = 1'b1;
    tick();
    wr(2'd0, 7'h0A);
    wr(2'd0, 7'h0A);
    chk_rd("ctrl0_flush", 2'd0, 32'h0E);
    phase = 8;
    exp_pulse(8, 2'b00, 2'b01);
    port_ready[0] = 1'b1;
    port_req[0]   = 1'b0;
    tick();
    port_ready[0] = 1'b0;
    repeat (2) tick();
    chk_rd("ctrl0_flush_done", 2'd0, 32'h08);

    // Reset mid-transaction with flush pending.
    phase = 9;
    port_req[0] = 1'b1;
    tick();
    wr(2'd0, 7'h0A);
    chk_rd("ctrl0_pre_rst", 2'd0, 32'h0E);
    rst_n = 1'b0;
    tick();
    chk("midrst_ctrl0", S_RDATA, 32'h1);
    chk("midrst_port_reset", S_PRST, 32'h3);
    chk("midrst_port_flush", S_PFL, 32'h0);
    chk("midrst_busy", S_BUSY, 32'h1);
    chk("midrst_page", S_PAGE, 32'h0);
    tick();
    phase = 10;
    exp_pulse(10, 2'b11, 2'b00);
    port_req = '0;
    rst_n    = 1'b1;
    tick();
    chk("rerelease_busy", S_BUSY, 32'h0);
    repeat (3) tick();

    while (pq.size() > 0) begin
      pe = pq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_pulse: got none expected phase %0d reset=%b flush=%b",
               pe.ph, pe.rst, pe.fl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
